// File: rtl/rbm_core_bwd_if.sv
// Bus bundle for the backward (reconstruction) RBM core.
// Groups the control handshake, the weight/bias memory read ports and the
// visible-probability output stream.
//   master : the core side (drives strobes, addresses, status and the stream)
//   slave  : the environment side (memories, controller, stream consumer)
// Signals:
//   start/h_bits        pass request and sampled hidden vector
//   busy/done           pass status, done is a one-cycle pulse
//   w_re/w_addr/w_rdata weight read port, data one cycle after strobe
//   b_re/b_addr/b_rdata visible-bias read port, data one cycle after strobe
//   v_valid/v_ready     output stream handshake
//   v_data/v_idx/v_acc  probability, visible index, pre-sigmoid accumulator
interface rbm_core_bwd_if #(
  parameter int I_DIM = 256,
  parameter int H_DIM = 64,
  parameter int W_AW  = $clog2(I_DIM * H_DIM),
  parameter int B_AW  = $clog2(I_DIM)
);
  logic              start;
  logic [H_DIM-1:0]  h_bits;
  logic              busy;
  logic              done;
  logic              w_re;
  logic [W_AW-1:0]   w_addr;
  logic [15:0]       w_rdata;
  logic              b_re;
  logic [B_AW-1:0]   b_addr;
  logic [31:0]       b_rdata;
  logic              v_valid;
  logic              v_ready;
  logic [15:0]       v_data;
  logic [B_AW-1:0]   v_idx;
  logic [31:0]       v_acc;

  modport master (
    input  start, h_bits, w_rdata, b_rdata, v_ready,
    output busy, done, w_re, w_addr, b_re, b_addr, v_valid, v_data, v_idx, v_acc
  );

  modport slave (
    output start, h_bits, w_rdata, b_rdata, v_ready,
    input  busy, done, w_re, w_addr, b_re, b_addr, v_valid, v_data, v_idx, v_acc
  );
endinterface

// File: rtl/rbm_core_bwd.sv
// Backward (reconstruction) GEMV + sigmoid for the RBM:
//   p_v[i] = sigmoid(b_v[i] + sum_j h[j] * W[i][j])
// One row of the weight memory is read per visible unit, the binary hidden
// vector gates each weight into a 32-bit wrapping accumulator, and the result
// goes through a piecewise-linear sigmoid to a Q0.16 probability.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   bus      : rbm_core_bwd_if.master (control, weight/bias reads, output stream)

// Piecewise-linear sigmoid with a registered output.
// x is signed Q7.9 (acc[21:6] with weights in Q1.15), y is Q0.16.
// Segments on |x|: [0,1) 0.25|x|+0.5, [1,2.375) 0.125|x|+0.625,
// [2.375,5) 0.03125|x|+0.84375, >=5 -> 1.0. Negative x uses 1 - f(|x|).
module sigmoid_lut (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] x,
  output logic [15:0] y
);
  logic [15:0] mag;
  logic [16:0] ypos;
  logic [15:0] y_next;

  always_comb begin
    // |x| fits in 16 unsigned bits even for -32768
    mag = x[15] ? (~x + 16'd1) : x;
    if (mag < 16'd512)
      ypos = {3'b000, mag[8:0], 5'b00000} + 17'd32768;
    else if (mag < 16'd1216)
      ypos = {2'b00, mag[10:0], 4'b0000} + 17'd40960;
    else if (mag < 16'd2560)
      ypos = {3'b000, mag[11:0], 2'b00} + 17'd55296;
    else
      ypos = 17'd65536;
    if (x[15])
      y_next = 16'(17'd65536 - ypos);
    else if (ypos[16])
      y_next = 16'hFFFF;  // 1.0 is not representable in Q0.16
    else
      y_next = ypos[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) y <= '0;
    else     y <= y_next;
  end
endmodule

module rbm_core_bwd #(
  parameter int I_DIM = 256,
  parameter int H_DIM = 64,
  parameter int W_AW  = $clog2(I_DIM * H_DIM),
  parameter int B_AW  = $clog2(I_DIM)
) (
  input logic          clk,
  input logic          rst,
  rbm_core_bwd_if.master bus
);
  // j runs 0..H_DIM inclusive: one extra slot to absorb the last read latency
  localparam int JW  = $clog2(H_DIM + 1);
  localparam int HIW = (H_DIM > 1) ? $clog2(H_DIM) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_BIAS, S_ACC, S_SIG, S_CAP, S_OUT, S_DONE
  } state_t;

  state_t           state_reg, state_next;
  logic [H_DIM-1:0] h_reg, h_next;
  logic [B_AW-1:0]  i_reg, i_next;
  logic [JW-1:0]    j_reg, j_next;
  logic [31:0]      acc_reg, acc_next;
  logic             w_re_reg, w_re_next;
  logic [W_AW-1:0]  w_addr_reg, w_addr_next;
  logic             b_re_reg, b_re_next;
  logic [B_AW-1:0]  b_addr_reg, b_addr_next;
  logic             v_valid_reg, v_valid_next;
  logic [15:0]      v_data_reg, v_data_next;
  logic [B_AW-1:0]  v_idx_reg, v_idx_next;
  logic [31:0]      v_acc_reg, v_acc_next;

  logic [15:0]      sig_y;
  logic [W_AW-1:0]  row_base;
  logic [JW-1:0]    j_inc;
  logic [HIW-1:0]   h_idx;
  logic [31:0]      w_term;

  sigmoid_lut u_sig (
    .clk (clk),
    .rst (rst),
    .x   (acc_reg[21:6]),
    .y   (sig_y)
  );

  assign row_base = W_AW'(i_reg) * W_AW'(H_DIM);
  assign j_inc    = j_reg + JW'(1);
  // At slot j the read data on w_rdata belongs to column j-1
  assign h_idx    = HIW'(j_reg - JW'(1));
  assign w_term   = h_reg[h_idx] ? {{16{bus.w_rdata[15]}}, bus.w_rdata} : 32'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      h_reg       <= '0;
      i_reg       <= '0;
      j_reg       <= '0;
      acc_reg     <= '0;
      w_re_reg    <= 1'b0;
      w_addr_reg  <= '0;
      b_re_reg    <= 1'b0;
      b_addr_reg  <= '0;
      v_valid_reg <= 1'b0;
      v_data_reg  <= '0;
      v_idx_reg   <= '0;
      v_acc_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      h_reg       <= h_next;
      i_reg       <= i_next;
      j_reg       <= j_next;
      acc_reg     <= acc_next;
      w_re_reg    <= w_re_next;
      w_addr_reg  <= w_addr_next;
      b_re_reg    <= b_re_next;
      b_addr_reg  <= b_addr_next;
      v_valid_reg <= v_valid_next;
      v_data_reg  <= v_data_next;
      v_idx_reg   <= v_idx_next;
      v_acc_reg   <= v_acc_next;
    end
  end

  // Strobes and addresses are computed one cycle ahead so the memory ports
  // are driven straight from flops during BIAS/ACC.
  always_comb begin
    state_next   = state_reg;
    h_next       = h_reg;
    i_next       = i_reg;
    j_next       = j_reg;
    acc_next     = acc_reg;
    w_re_next    = 1'b0;
    w_addr_next  = w_addr_reg;
    b_re_next    = 1'b0;
    b_addr_next  = b_addr_reg;
    v_valid_next = v_valid_reg;
    v_data_next  = v_data_reg;
    v_idx_next   = v_idx_reg;
    v_acc_next   = v_acc_reg;

    case (state_reg)
      S_IDLE: begin
        if (bus.start) begin
          h_next      = bus.h_bits;
          i_next      = '0;
          b_re_next   = 1'b1;
          b_addr_next = '0;
          state_next  = S_BIAS;
        end
      end
      S_BIAS: begin
        j_next      = '0;
        w_re_next   = 1'b1;
        w_addr_next = row_base;
        state_next  = S_ACC;
      end
      S_ACC: begin
        if (j_reg == '0) acc_next = bus.b_rdata;
        else             acc_next = acc_reg + w_term;
        if (j_reg == JW'(H_DIM)) begin
          state_next = S_SIG;
        end else begin
          j_next = j_inc;
          if (j_inc != JW'(H_DIM)) begin
            w_re_next   = 1'b1;
            w_addr_next = row_base + W_AW'(j_inc);
          end
        end
      end
      S_SIG: begin
        // LUT output registers at the end of this cycle
        state_next = S_CAP;
      end
      S_CAP: begin
        v_data_next  = sig_y;
        v_acc_next   = acc_reg;
        v_idx_next   = i_reg;
        v_valid_next = 1'b1;
        state_next   = S_OUT;
      end
      S_OUT: begin
        if (bus.v_ready) begin
          v_valid_next = 1'b0;
          if (i_reg == B_AW'(I_DIM - 1)) begin
            state_next = S_DONE;
          end else begin
            i_next      = i_reg + B_AW'(1);
            b_re_next   = 1'b1;
            b_addr_next = i_reg + B_AW'(1);
            state_next  = S_BIAS;
          end
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign bus.busy    = (state_reg != S_IDLE);
  assign bus.done    = (state_reg == S_DONE);
  assign bus.w_re    = w_re_reg;
  assign bus.w_addr  = w_addr_reg;
  assign bus.b_re    = b_re_reg;
  assign bus.b_addr  = b_addr_reg;
  assign bus.v_valid = v_valid_reg;
  assign bus.v_data  = v_data_reg;
  assign bus.v_idx   = v_idx_reg;
  assign bus.v_acc   = v_acc_reg;
endmodule
